// File: rtl/ss_pkg.sv
// Shared definitions for the ForthSuper data stack: the operation
// encoding seen on the ss_io interface and a sizing helper for the
// stack pointer.
package ss_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } ss_op;

  // Pointer must count 0..depth inclusive, hence one bit more than the
  // address width.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : ss_pkg

// File: rtl/ss_io.sv
// Master/slave link between the CPU's top-of-stack logic and the stack
// cells beneath it. The master issues one operation per clock through
// the push/pop methods; op holds its value until the master changes it.
interface ss_io
  import ss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32
) ();

  ss_op           op = NOP;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] s0;
  logic           full;
  logic           empty;

  // Request a push of v on the next enabled edge.
  task automatic push(input logic [DSZ-1:0] v);
    op = PUSH;
    vi = v;
  endtask

  // Request a pop; the returned value is the top cell before the
  // edge that commits the pop.
  function automatic logic [DSZ-1:0] pop();
    op = POP;
    return s0;
  endfunction

  // Stop issuing operations.
  task automatic idle();
    op = NOP;
  endtask

  // Number of cells the slave can hold.
  function automatic int capacity();
    return DEPTH;
  endfunction

  modport master (
    output op,
    output vi,
    input  s0,
    input  full,
    input  empty,
    import push,
    import pop,
    import idle,
    import capacity
  );

  modport slave (
    input  op,
    input  vi,
    output s0,
    output full,
    output empty
  );

endinterface : ss_io

// File: rtl/stack_ram.sv
// Cell storage for the data stack: synchronous write, asynchronous read.
// Contents are deliberately not reset; a cell only becomes visible once
// the stack pointer covers it, which implies it was written first.
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DSZ-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [DSZ-1:0] rdata
);

  logic [DSZ-1:0] mem_r [DEPTH];

  // Write the pushed cell at the current stack pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : stack_ram

// File: rtl/stack.sv
// LIFO data stack holding the cells beneath the CPU's cached top of
// stack. sp counts stored cells; the top cell lives at sp-1. Pushes to a
// full stack and pops from an empty one are dropped without wrapping.
module stack
  import ss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  ss_io.slave  ss_if
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = sp_width(DEPTH);

  localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
  localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [SPW-1:0] sp_r;
  logic [SPW-1:0] sp_nxt_s;
  logic [SPW-1:0] sp_dec_s;
  logic           push_ok_s;
  logic           full_s;
  logic           empty_s;
  logic [AW-1:0]  waddr_s;
  logic [AW-1:0]  raddr_s;
  logic [DSZ-1:0] rdata_s;
  logic [DSZ-1:0] s0_s;

  assign full_s   = (sp_r == SP_FULL);
  assign empty_s  = (sp_r == SP_ZERO);
  assign sp_dec_s = sp_r - SP_ONE;
  assign waddr_s  = sp_r[AW-1:0];
  assign raddr_s  = sp_dec_s[AW-1:0];

  // Accept or drop the requested operation and work out the next pointer.
  always_comb begin
    push_ok_s = 1'b0;
    sp_nxt_s  = sp_r;
    if (en) begin
      case (ss_if.op)
        PUSH: begin
          if (!full_s) begin
            push_ok_s = 1'b1;
            sp_nxt_s  = sp_r + SP_ONE;
          end else begin
            push_ok_s = 1'b0;
            sp_nxt_s  = sp_r;
          end
        end
        POP: begin
          if (!empty_s) begin
            sp_nxt_s = sp_dec_s;
          end else begin
            sp_nxt_s = sp_r;
          end
        end
        NOP: begin
          sp_nxt_s = sp_r;
        end
        default: begin
          sp_nxt_s = sp_r;
        end
      endcase
    end else begin
      sp_nxt_s = sp_r;
    end
  end

  // Stack pointer register; reset empties the stack without touching cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= SP_ZERO;
    end else begin
      sp_r <= sp_nxt_s;
    end
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .DSZ   (DSZ),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (waddr_s),
    .wdata (ss_if.vi),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Top cell is visible only while the stack holds something.
  always_comb begin
    s0_s = {DSZ{1'b0}};
    if (!empty_s) begin
      s0_s = rdata_s;
    end else begin
      s0_s = {DSZ{1'b0}};
    end
  end

  assign ss_if.s0    = s0_s;
  assign ss_if.full  = full_s;
  assign ss_if.empty = empty_s;

endmodule : stack

// File: tb/tb_stack.sv
// Self-checking bench for the data stack: a vector table, directed
// corner-case sequences and randomized traffic checked against a
// queue-based LIFO model.
module tb_stack;
  import ss_pkg::*;

  localparam int DEPTH = 16;
  localparam int DSZ   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  ss_io #(.DEPTH(DEPTH), .DSZ(DSZ)) ss ();

  stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .ss_if (ss.slave)
  );

  logic [DSZ-1:0] mq[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    ss_op           op;
    logic [DSZ-1:0] vi;
    logic           en;
    logic [DSZ-1:0] s0;
    logic           full;
    logic           empty;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [DSZ-1:0] model_top();
    if (mq.size() == 0) return '0;
    return mq[$];
  endfunction

  task automatic check(input string name, input logic [DSZ-1:0] act, input logic [DSZ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_s0"},    ss.s0,    model_top());
    check({name, "_full"},  ss.full,  (mq.size() == DEPTH) ? 32'd1 : 32'd0);
    check({name, "_empty"}, ss.empty, (mq.size() == 0) ? 32'd1 : 32'd0);
  endtask

  // Advance one clock: the model applies the LIFO rule to whatever is
  // being driven, then the edge happens and outputs settle.
  task automatic step();
    if (rst_n && en) begin
      if (ss.op == PUSH && mq.size() < DEPTH) mq.push_back(ss.vi);
      else if (ss.op == POP && mq.size() > 0) void'(mq.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DSZ-1:0] got;
    int push_w;

    vecs[0] = '{op: PUSH, vi: 32'd11, en: 1'b1, s0: 32'd11, full: 1'b0, empty: 1'b0};
    vecs[1] = '{op: PUSH, vi: 32'd22, en: 1'b1, s0: 32'd22, full: 1'b0, empty: 1'b0};
    vecs[2] = '{op: PUSH, vi: 32'd33, en: 1'b0, s0: 32'd22, full: 1'b0, empty: 1'b0};
    vecs[3] = '{op: POP,  vi: 32'd0,  en: 1'b1, s0: 32'd11, full: 1'b0, empty: 1'b0};
    vecs[4] = '{op: POP,  vi: 32'd0,  en: 1'b0, s0: 32'd11, full: 1'b0, empty: 1'b0};
    vecs[5] = '{op: POP,  vi: 32'd0,  en: 1'b1, s0: 32'd0,  full: 1'b0, empty: 1'b1};
    vecs[6] = '{op: POP,  vi: 32'd0,  en: 1'b1, s0: 32'd0,  full: 1'b0, empty: 1'b1};
    vecs[7] = '{op: PUSH, vi: 32'd44, en: 1'b1, s0: 32'd44, full: 1'b0, empty: 1'b0};

    // Reset held for two clocks with a push pending.
    en = 1'b1;
    ss.push(32'd77);
    repeat (2) step();
    mq.delete();
    check("rst_s0", ss.s0, 32'd0);
    check("rst_empty", ss.empty, 32'd1);
    check("rst_full", ss.full, 32'd0);
    check("rst_sp", dut.sp_r, 32'd0);
    ss.idle();
    rst_n = 1'b1;
    step();
    check_state("post_rst");

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      ss.op = vecs[i].op;
      ss.vi = vecs[i].vi;
      en    = vecs[i].en;
      step();
      check($sformatf("vec%0d_s0", i), ss.s0, vecs[i].s0);
      check($sformatf("vec%0d_full", i), ss.full, vecs[i].full);
      check($sformatf("vec%0d_empty", i), ss.empty, vecs[i].empty);
      check_state($sformatf("vec%0d_model", i));
    end

    // Return to empty.
    en = 1'b1;
    void'(ss.pop());
    step();
    ss.idle();
    check_state("cleared");

    // Fill with 1000..1014.
    for (int i = 0; i < 15; i++) begin
      ss.push(32'd1000 + 32'(i));
      step();
      check($sformatf("fill%0d_s0", i), ss.s0, 32'd1000 + 32'(i));
      check($sformatf("fill%0d_empty", i), ss.empty, 32'd0);
      check($sformatf("fill%0d_full", i), ss.full, 32'd0);
    end

    // Drain with 16 pops; the last is an underflow.
    for (int i = 0; i < 16; i++) begin
      got = ss.pop();
      check($sformatf("drain%0d_ret", i), got, (i < 15) ? 32'd1014 - 32'(i) : 32'd0);
      step();
    end
    check("drain_s0", ss.s0, 32'd0);
    check("drain_empty", ss.empty, 32'd1);

    // Overflow: 17 pushes of 0..16.
    for (int i = 0; i < 17; i++) begin
      ss.push(32'(i));
      step();
      if (i >= 15) begin
        check($sformatf("ovf%0d_full", i), ss.full, 32'd1);
        check($sformatf("ovf%0d_s0", i), ss.s0, 32'd15);
      end else begin
        check($sformatf("ovf%0d_full", i), ss.full, 32'd0);
        check($sformatf("ovf%0d_s0", i), ss.s0, 32'(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      got = ss.pop();
      check($sformatf("ovfpop%0d_ret", i), got, 32'd15 - 32'(i));
      step();
    end
    ss.idle();
    check_state("ovf_end");

    // Enable gating.
    ss.push(32'd5);
    step();
    en = 1'b0;
    ss.push(32'd9);
    repeat (3) step();
    check("engate_s0", ss.s0, 32'd5);
    check("engate_sp", dut.sp_r, 32'd1);
    en = 1'b1;
    ss.idle();
    step();

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      ss.push(32'd100 + 32'(i));
      step();
    end
    check("areset_pre_s0", ss.s0, 32'd102);
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check("areset_s0", ss.s0, 32'd0);
    check("areset_empty", ss.empty, 32'd1);
    check("areset_sp", dut.sp_r, 32'd0);
    ss.idle();
    step();
    rst_n = 1'b1;
    ss.push(32'd7);
    step();
    check("areset_push7", ss.s0, 32'd7);
    check_state("areset_end");

    // Randomized traffic: push-heavy phase then pop-heavy phase.
    for (int p = 0; p < 2; p++) begin
      push_w = (p == 0) ? 6 : 3;
      for (int i = 0; i < 200; i++) begin
        int r;
        r  = int'($urandom_range(0, 9));
        en = ($urandom_range(0, 7) != 0);
        if (r < push_w) begin
          ss.push($urandom);
        end else if (r < 8) begin
          got = ss.pop();
          check("rnd_popret", got, model_top());
        end else begin
          ss.idle();
        end
        step();
        check_state("rnd");
      end
    end

    ss.idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stack
